// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT butterfly issue logic.
// Complex words are packed {re, im}, each component signed.
package fft_pkg;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    DRAIN
  } state_t;

  localparam int DEF_X_WDTH = 16;
  localparam int DEF_CPLX_W = 2 * DEF_X_WDTH;

  function automatic int cplx_width(input int x_wdth);
    return 2 * x_wdth;
  endfunction

  function automatic logic [DEF_CPLX_W-1:0] cplx_pack(input logic [DEF_X_WDTH-1:0] re,
                                                       input logic [DEF_X_WDTH-1:0] im);
    return {re, im};
  endfunction

  function automatic logic [DEF_X_WDTH-1:0] cplx_re(input logic [DEF_CPLX_W-1:0] word);
    return word[DEF_CPLX_W-1:DEF_X_WDTH];
  endfunction

  function automatic logic [DEF_X_WDTH-1:0] cplx_im(input logic [DEF_CPLX_W-1:0] word);
    return word[DEF_X_WDTH-1:0];
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One-frame sample store: single write port, two async read ports that
// return the butterfly pair x[j] and x[j+N/2] for a given pair index j.
module fft_frame_buf #(
  parameter int LOG_N = 3,
  parameter int WDTH  = 32
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LOG_N-1:0] wr_addr,
  input  logic [WDTH-1:0]  wr_data,
  input  logic [LOG_N-2:0] rd_addr,
  output logic [WDTH-1:0]  rd_a,
  output logic [WDTH-1:0]  rd_b
);

  logic [WDTH-1:0] mem [1 << LOG_N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The top address bit selects the lower or upper half of the frame.
  assign rd_a = mem[{1'b0, rd_addr}];
  assign rd_b = mem[{1'b1, rd_addr}];

endmodule

// File: rtl/fft_bf_driver.sv
// Issue-side controller for the radix-2 butterfly: fills a frame, issues
// N/2 operations at most every other cycle, then waits for all completions.
module fft_bf_driver
  import fft_pkg::*;
#(
  parameter int LOG_N  = 3,
  parameter int X_WDTH = 16,
  parameter int M_WDTH = LOG_N - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*X_WDTH-1:0]   in_data,
  input  logic                  in_nd,
  output logic                  in_ready,
  output logic [LOG_N-2:0]      tw_addr,
  input  logic [2*X_WDTH-1:0]   tw_data,
  output logic [2*X_WDTH-1:0]   bf_xa,
  output logic [2*X_WDTH-1:0]   bf_xb,
  output logic [2*X_WDTH-1:0]   bf_w,
  output logic [M_WDTH-1:0]     bf_m_in,
  output logic                  bf_x_nd,
  input  logic                  bf_y_nd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int CW   = cplx_width(X_WDTH);

  localparam logic [LOG_N-1:0] LAST_WR  = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] ALL_BACK = LOG_N'(HALF);
  localparam logic [LOG_N-2:0] LAST_J   = (LOG_N-1)'(HALF - 1);

  state_t state, state_nxt;

  logic [LOG_N-1:0] wr_ptr;
  logic [LOG_N-1:0] cmp_cnt;
  logic [LOG_N-2:0] j;
  logic             phase;
  logic             accept;
  logic             load;
  logic             last_pair;
  logic             drain_done;
  logic [CW-1:0]    rd_a;
  logic [CW-1:0]    rd_b;

  // Gating with rst_n keeps every output low while reset is held.
  assign in_ready   = rst_n && (state == FILL);
  assign accept     = in_nd && in_ready;
  assign load       = (state == ISSUE) && !phase;
  assign last_pair  = (state == ISSUE) && phase && (j == LAST_J);
  assign drain_done = (state == DRAIN) && (cmp_cnt == ALL_BACK);
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign tw_addr    = j;

  fft_frame_buf #(
    .LOG_N (LOG_N),
    .WDTH  (CW)
  ) frame_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (j),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && (wr_ptr == LAST_WR)) state_nxt = ISSUE;
      ISSUE:   if (last_pair) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Pointers wrap naturally because N and N/2 are powers of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      j       <= '0;
      phase   <= 1'b0;
      cmp_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + LOG_N'(1);
      phase <= (state == ISSUE) ? ~phase : 1'b0;
      if ((state == ISSUE) && phase) j <= j + (LOG_N-1)'(1);
      if (drain_done) cmp_cnt <= '0;
      else if (bf_y_nd && (state != FILL)) cmp_cnt <= cmp_cnt + LOG_N'(1);
      done <= drain_done;
      if ((in_nd && !in_ready) || (bf_y_nd && (state == FILL))) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_x_nd <= 1'b0;
      bf_xa   <= '0;
      bf_xb   <= '0;
      bf_w    <= '0;
      bf_m_in <= '0;
    end else begin
      bf_x_nd <= load;
      if (load) begin
        bf_xa   <= rd_a;
        bf_xb   <= rd_b;
        bf_w    <= tw_data;
        bf_m_in <= M_WDTH'(j);
      end
    end
  end

endmodule
